mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the word-only data RAM (2**n words x m bits, async read, sync write on MemWR).
- Takes byte-addressed requests from the CPU MEM stage: LB/LBU/LH/LHU/LW/SB/SH/SW.
- Performs lane extraction and sign/zero extension on loads.
- Builds sub-word stores by read-modify-write, checks alignment, and returns one response per request.

Parameters:
- n, 5, RAM word-address width; byte address is n+2 bits.
- m, 32, data width; fixed at 32 (byte/half lane logic assumes 4 byte lanes).

Ports:
- Clk  in  1  single system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept; handshake when ReqValid&ReqReady at posedge Clk.
- ReqWrite  in  1  1=store, 0=load.
- ReqSize  in  2  00=byte, 01=half, 10=word, 11=illegal.
- ReqSigned  in  1  loads only: 1=sign-extend, 0=zero-extend.
- ReqAddr  in  n+2  byte address.
- ReqWData  in  m  store data; the relevant lane is the low byte/half/word.
- RspValid  out  1  one-cycle response pulse; no back-pressure.
- RspRData  out  m  load result; 0 for stores and errors.
- RspErr  out  1  misaligned or illegal size; valid with RspValid.
- RamAddr  out  n  word address to RAM = latched ReqAddr[n+1:2].
- RamDataIn  out  m  write data to RAM.
- RamMemWR  out  1  RAM write enable, active high.
- RamDataOut  in  m  async read data from RAM.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset (Reset_n=0, async) -> IDLE; all latched fields cleared.
- Output reset values: RspValid=0, RspRData=0, RspErr=0, RamMemWR=0, RamAddr=0, RamDataIn=0. ReqReady=1 (IDLE), but no request is accepted while Reset_n=0.
- ReqReady=1 only in IDLE. On handshake, latch ReqWrite, ReqSize, ReqSigned, ReqAddr and ReqWData.
- Error check at accept:
  - size 11 -> error.
  - half with addr[0]=1 -> error.
  - word with addr[1:0]!=0 -> error.
  - Error path: IDLE->RESP with RspErr=1, RspRData=0, no RAM write.
- Transitions from IDLE:
  - Load: IDLE->READ.
  - SW: IDLE->WRITE.
  - SB/SH: IDLE->READ.
- READ: capture RamDataOut into an old-word register. Load -> RESP; sub-word store -> WRITE.
- WRITE: RamMemWR=1 for exactly this one cycle.
  - RamDataIn = ReqWData for SW.
  - For SB/SH: old word with the target lane(s) replaced (little-endian; byte lane = addr[1:0], half lane = addr[1]).
  - Next state RESP.
- RESP: RspValid=1 for one cycle. RspRData = extracted load lane, extended per ReqSigned (LW ignores ReqSigned); 0 for stores. Next state IDLE.
- RamAddr is driven from the latched address in READ/WRITE/RESP; 0 in IDLE. RamDataIn=0 and RamMemWR=0 outside WRITE.
- Latency, counted in edges from the accept edge to the first edge at which RspValid=1 is sampled:
  - Error: 1 (RspValid high in the cycle after accept).
  - Load, SW: 2.
  - SB/SH: 3.
- Throughput: the next request can be accepted in the cycle after RESP, i.e. the cycle after RspValid.
- Reset mid-operation: RamMemWR drops immediately (async) and the FSM returns to IDLE. No response is issued for the aborted request. A reset asserted in READ leaves RAM untouched.
- ReqValid deasserting while not ready is legal and ignored. Inputs are not sampled outside the accept edge.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles -> all outputs at reset values, ReqReady=1, no accept. Release, then SW addr 0x04 data 0xDEADBEEF -> RamMemWR=1 for one cycle with RamAddr=1, RspValid 2 edges after accept, RspErr=0.
- Loads on word 1=0x8081F0F7:
  - LB addr 0x04 -> 0xFFFFFFF7; LBU addr 0x07 -> 0x00000080.
  - LH addr 0x06 -> 0xFFFF8081; LHU addr 0x04 -> 0x0000F0F7.
  - LW addr 0x04 -> 0x8081F0F7.
  - Each RspValid 2 edges after accept.
- Sub-word stores, word 2 preset to 0x11223344:
  - SB addr 0x09 data 0xAA -> RAM word 2 = 0x1122AA44.
  - Then SH addr 0x0A data 0xBEEF -> 0xBEEFAA44.
  - RspValid 3 edges after each accept; exactly one RamMemWR pulse per store.
- Errors:
  - LH addr 0x01 -> RspErr=1, RspRData=0.
  - SW addr 0x06 -> RspErr=1, RamMemWR never asserted.
  - ReqSize=11 -> RspErr=1.
  - Each RspValid 1 edge after accept.
- Back-to-back: ReqValid held high with 4 queued requests -> ReqReady low from accept through RESP; each request accepted exactly once, in order; responses match.
- Reset mid-op: assert Reset_n=0 during READ of SB addr 0x0D -> no RamMemWR, no RspValid, RAM word 3 unchanged, FSM in IDLE after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a word-only RAM.
// It extracts and extends load lanes, and builds sub-word stores by
// read-modify-write. It returns exactly one response per accepted request,
// and it flags misaligned accesses and the illegal size encoding.
module mem_access_unit #(
  parameter int n = 5,
  parameter int m = 32
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWrite,
  input  logic [1:0]   ReqSize,
  input  logic         ReqSigned,
  input  logic [n+1:0] ReqAddr,
  input  logic [m-1:0] ReqWData,
  output logic         RspValid,
  output logic [m-1:0] RspRData,
  output logic         RspErr,
  output logic [n-1:0] RamAddr,
  output logic [m-1:0] RamDataIn,
  output logic         RamMemWR,
  input  logic [m-1:0] RamDataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateT;

  stateT        state;
  logic         reqWrite;
  logic [1:0]   reqSize;
  logic         reqSigned;
  logic [n+1:0] reqAddr;
  logic [15:0]  reqWLow;

  // Size 11 is illegal. Halves need an even address. Words need a 4-byte aligned address.
  function automatic logic badAccess(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Pick the addressed byte or half out of the RAM word, then sign- or zero-extend it.
  function automatic logic [m-1:0] extractLoad(input logic [m-1:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
    logic [7:0]   b;
    logic [15:0]  h;
    logic [m-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{(m-8){sgn & b[7]}}, b};
      2'b01:   r = {{(m-16){sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the target byte or half lane of the old word (little-endian) with the store data.
  function automatic logic [m-1:0] mergeStore(input logic [m-1:0] old, input logic [15:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [m-1:0] r;
    r = old;
    if (size == 2'b00)
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    else
      r[{lane[1], 4'b0000} +: 16] = wdata;
    return r;
  endfunction

  assign ReqReady = (state == IDLE);
  assign RamAddr  = (state == IDLE) ? '0 : reqAddr[n+1:2];

  // Request sequencer: accept, optional RAM read, optional single write cycle, one response pulse.
  // The merged store word is computed from the old word during READ and is held in RamDataIn for WRITE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      reqWrite  <= 1'b0;
      reqSize   <= 2'b00;
      reqSigned <= 1'b0;
      reqAddr   <= '0;
      reqWLow   <= '0;
      RspValid  <= 1'b0;
      RspRData  <= '0;
      RspErr    <= 1'b0;
      RamDataIn <= '0;
      RamMemWR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            reqWrite  <= ReqWrite;
            reqSize   <= ReqSize;
            reqSigned <= ReqSigned;
            reqAddr   <= ReqAddr;
            reqWLow   <= ReqWData[15:0];
            if (badAccess(ReqSize, ReqAddr[1:0])) begin
              state    <= RESP;
              RspValid <= 1'b1;
              RspErr   <= 1'b1;
              RspRData <= '0;
            end else if (ReqWrite && (ReqSize == 2'b10)) begin
              state     <= WRITE;
              RamMemWR  <= 1'b1;
              RamDataIn <= ReqWData;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (reqWrite) begin
            state     <= WRITE;
            RamMemWR  <= 1'b1;
            RamDataIn <= mergeStore(RamDataOut, reqWLow, reqSize, reqAddr[1:0]);
          end else begin
            state    <= RESP;
            RspValid <= 1'b1;
            RspErr   <= 1'b0;
            RspRData <= extractLoad(RamDataOut, reqSize, reqSigned, reqAddr[1:0]);
          end
        end
        WRITE: begin
          state     <= RESP;
          RamMemWR  <= 1'b0;
          RamDataIn <= '0;
          RspValid  <= 1'b1;
          RspErr    <= 1'b0;
          RspRData  <= '0;
        end
        RESP: begin
          state    <= IDLE;
          RspValid <= 1'b0;
          RspErr   <= 1'b0;
          RspRData <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
